// File: rtl/cmd_sched.sv
// Host command scheduler: queues host commands and sequences them to the
// command processor, returning one response byte per command.
module cmd_sched #(
    parameter int          DEPTH   = 4,
    parameter logic [23:0] TMO_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] host_cmd,
    input  logic        host_vld,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_vld,
    output logic        host_full,
    output logic        ovf,
    output logic        tmo_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [23:0]   timer_q, timer_d;
    logic [7:0]    resp_q, resp_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          pop;
    logic          push;
    logic          full;

    assign full      = (count_q == FULL);
    assign host_full = full;
    assign cmd       = mem_q[rd_ptr_q];
    assign cmd_rdy   = (state_q == ISSUE);
    assign resp      = resp_q;
    assign resp_vld  = (state_q == RESP) && !abort;
    assign ovf       = ovf_q;
    assign tmo_err   = tmo_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) state_d = ISSUE;
                end
                ISSUE: begin
                    if (clr_cmd_rdy) begin
                        pop     = 1'b1;
                        timer_d = '0;
                        // opcodes 0..3 need the processor, 4..7 answer at once
                        if (!cmd[15]) begin
                            state_d = BUSY;
                        end else begin
                            state_d = RESP;
                            resp_d  = 8'h5A;
                        end
                    end
                end
                BUSY: begin
                    timer_d = timer_q + 24'd1;
                    if (send_resp) begin
                        state_d = RESP;
                        resp_d  = 8'hA5;
                    end else if (timer_q == TMO_CYC - 24'd1) begin
                        state_d = RESP;
                        resp_d  = 8'hEE;
                        tmo_d   = 1'b1;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        push     = host_vld && !abort && (!full || pop);
        ovf_d    = ovf_q | (host_vld && !abort && full && !pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (abort) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            resp_q   <= 8'h00;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            resp_q   <= resp_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule
